bar_graph_frame_scheduler: RTL and testbench
============================================

Name: bar_graph_frame_scheduler

Overview:
Upstream sequencer for the bar-graph pixel path in the coin price visual. Keeps a history of the last NUM_BARS price samples, already scaled to pixel height. On a redraw request it walks every bar slot and emits one pixel per cycle (x, y, colour, plot) to the VGA adapter. Each bar column is repainted over its full height, so bar fill and background clear happen in a single pass.

Parameters:
NUM_BARS, 8, number of bars / history depth (2..16)
BAR_W, 32, bar width in pixels (power of 2)
BAR_GAP, 8, blank pixels between bars (never painted)
GRAPH_H, 200, graph height in pixels; sample clamp ceiling
BASE_X, 40, x of left edge of bar 0
BASE_Y, 140, y of top row of the graph area
UP_COLOUR, 3'b010, colour of bar whose sample >= previous bar's sample
DOWN_COLOUR, 3'b100, colour of bar whose sample < previous bar's sample
BG_COLOUR, 3'b000, colour of unfilled rows in a bar column

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
sample_valid  in  1  one-cycle strobe: new price sample
sample_value  in  8  new sample height, 0..255; clamped to GRAPH_H
redraw  in  1  one-cycle strobe: repaint all bars
x_coord  out  10  pixel x
y_coord  out  9  pixel y
colour  out  3  pixel colour
plot  out  1  pixel valid, write to frame buffer this cycle
busy  out  1  high from LOAD through DONE inclusive
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, resetn=0): state IDLE; history all 0; pending flags clear; x_coord=0, y_coord=0, colour=0, plot=0, busy=0, done=0. Reset mid-frame aborts immediately. No done pulse.
- History: shift register of NUM_BARS 8-bit entries. Slot NUM_BARS-1 is newest. A push shifts slot i+1 into slot i and drops slot 0.
- Clamp: stored = (sample_value > GRAPH_H) ? GRAPH_H : sample_value.
- sample_valid in IDLE: push on the next clock.
- sample_valid while busy: clamped value goes to a one-deep pending register; a later sample overwrites it (latest wins). Pending is pushed in the DONE cycle, so the history stays frozen during a frame.
- redraw in IDLE: go to LOAD. redraw while busy: set redraw_pending. After DONE, enter LOAD again instead of IDLE.
- Simultaneous sample_valid and redraw in IDLE: push first, then draw; the frame shows the new sample.
- FSM: IDLE -> LOAD (1 cycle; clear counters) -> DRAW -> DONE (1 cycle; done=1, plot=0) -> IDLE or LOAD.
- DRAW counters: bar b (0..NUM_BARS-1), row r (0..GRAPH_H-1), col c (0..BAR_W-1).
  - c is the inner loop; r advances on c wrap; b advances on r wrap.
  - Leaving DRAW: at b=NUM_BARS-1, r=GRAPH_H-1, c=BAR_W-1.
- Outputs are registered; plot=1 exactly on every DRAW pixel, with coordinates valid in the same cycle.
  - x_coord = BASE_X + b*(BAR_W+BAR_GAP) + c
  - y_coord = BASE_Y + r
  - colour = bar colour if r >= GRAPH_H - h[b], else BG_COLOUR. h=0 gives an all-background column; h=GRAPH_H gives a full column.
- Bar colour: bar 0 always UP_COLOUR. Bar b>0 is UP_COLOUR if h[b] >= h[b-1], else DOWN_COLOUR.
- Frame length: NUM_BARS*GRAPH_H*BAR_W plot cycles (51200 by default), plus LOAD and DONE.
- Arithmetic: coordinate sums done at full 10/9-bit width. Parameter legality requires max x < 640 and max y < 480 (default max x 351, max y 339); no wrap handling needed.

Decomposition:
- Package bar_graph_pkg: GRAPH_H, BAR_W, BAR_GAP, BASE_X, BASE_Y, colour constants, FSM state encoding (IDLE, LOAD, DRAW, DONE).
- Sub-module bar_history_buffer: clamp, shift register, pending register, push/freeze control; exposes h[] as a flat vector.
- The top module holds the FSM, pixel counters and output registers.

Test Plan:
- Reset then redraw with empty history -> 51200 plot cycles, all colour=000; first pixel (40,140); last pixel (351,339); done pulses once 1 cycle after the last plot.
- Push 8 samples 10,20,20,5,200,255,0,100, then redraw -> h = 10,20,20,5,200,200,0,100.
  - Bar 5 (clamped 255): fully coloured, UP.
  - Bar 3 (h=5): DOWN, coloured rows only at y 335..339.
  - Bar 6 (h=0): all background.
- sample_valid=1 with value 50 at DRAW cycle 1000, then value 60 at cycle 2000 -> frame uses the old history; after done, newest slot = 60 and 50 is never stored.
- redraw pulsed mid-frame -> done pulses, LOAD follows immediately, a second full frame runs, busy stays high throughout.
- resetn low for 1 cycle at DRAW cycle 3000 -> plot/busy drop asynchronously, history is all zero, no done pulse, the next redraw runs normally.

Source files
------------

// File: rtl/bar_graph_pkg.sv
// -----------------------------------------------------------------------------
// bar_graph_pkg
// Shared constants for the bar-graph pixel path:
//   - default graph geometry (height, bar width, gap, origin)
//   - colour constants for rising, falling and background pixels
//   - frame scheduler FSM state encoding
//   - sample clamp helper used by the history buffer
// -----------------------------------------------------------------------------
package bar_graph_pkg;

  localparam int GRAPH_H = 200;
  localparam int BAR_W   = 32;
  localparam int BAR_GAP = 8;
  localparam int BASE_X  = 40;
  localparam int BASE_Y  = 140;

  localparam logic [2:0] UP_COLOUR   = 3'b010;
  localparam logic [2:0] DOWN_COLOUR = 3'b100;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Limit a raw sample to the graph height. A ceiling above 255 never clips.
  function automatic logic [7:0] clamp_sample(input logic [7:0] v, input int ceiling);
    if (int'(v) > ceiling) begin
      return 8'(ceiling);
    end
    return v;
  endfunction

endpackage

// File: rtl/bar_history_buffer.sv
// -----------------------------------------------------------------------------
// bar_history_buffer
// Holds the last NUM_BARS clamped price samples. Slot NUM_BARS-1 is newest;
// a push shifts every slot down by one and drops slot 0.
// While a frame is in progress the history is frozen: incoming samples land
// in a one-deep pending register (latest wins) that is committed during the
// frame's final (DONE) cycle.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   sample_valid_i one-cycle strobe, new raw sample
//   sample_value_i raw sample height 0..255
//   freeze_i       frame in progress, divert samples to pending
//   commit_i       frame end cycle, push pending (or a same-cycle sample)
//   hist_o         flat history, slot i at bits [i*8 +: 8]
// -----------------------------------------------------------------------------
module bar_history_buffer #(
  parameter int NUM_BARS = 8,
  parameter int GRAPH_H  = bar_graph_pkg::GRAPH_H
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sample_valid_i,
  input  logic [7:0]            sample_value_i,
  input  logic                  freeze_i,
  input  logic                  commit_i,
  output logic [NUM_BARS*8-1:0] hist_o
);
  import bar_graph_pkg::*;

  logic [7:0] clamped;
  logic       push;
  logic [7:0] push_val;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] slot_q [NUM_BARS];

  assign clamped = clamp_sample(sample_value_i, GRAPH_H);

  always_comb begin
    push         = 1'b0;
    push_val     = clamped;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (commit_i) begin
      // A sample arriving in the commit cycle is newer than anything pending,
      // so it wins and the pending value is discarded.
      if (sample_valid_i) begin
        push = 1'b1;
      end else if (pend_valid_q) begin
        push     = 1'b1;
        push_val = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (freeze_i) begin
      if (sample_valid_i) begin
        pend_valid_d = 1'b1;
        pend_d       = clamped;
      end
    end else if (sample_valid_i) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      if (push) begin
        for (int i = 0; i < NUM_BARS - 1; i++) begin
          slot_q[i] <= slot_q[i+1];
        end
        slot_q[NUM_BARS-1] <= push_val;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_flat
    assign hist_o[gi*8 +: 8] = slot_q[gi];
  end

endmodule

// File: rtl/bar_graph_frame_scheduler.sv
// -----------------------------------------------------------------------------
// bar_graph_frame_scheduler
// On a redraw request, walks every bar column over its full height and emits
// one pixel per cycle to the VGA adapter. Filled rows take the bar colour
// (up if not lower than the previous bar, down otherwise); rows above the
// bar height are painted background, so fill and clear happen in one pass.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   sample_valid  one-cycle strobe with sample_value (new price height)
//   redraw        one-cycle strobe requesting a full repaint
//   x_coord       pixel x (registered)
//   y_coord       pixel y (registered)
//   colour        pixel colour (registered)
//   plot          pixel valid this cycle
//   busy          high from LOAD through DONE
//   done          one-cycle pulse in the DONE cycle
// -----------------------------------------------------------------------------
module bar_graph_frame_scheduler #(
  parameter int         NUM_BARS    = 8,
  parameter int         BAR_W       = bar_graph_pkg::BAR_W,
  parameter int         BAR_GAP     = bar_graph_pkg::BAR_GAP,
  parameter int         GRAPH_H     = bar_graph_pkg::GRAPH_H,
  parameter int         BASE_X      = bar_graph_pkg::BASE_X,
  parameter int         BASE_Y      = bar_graph_pkg::BASE_Y,
  parameter logic [2:0] UP_COLOUR   = bar_graph_pkg::UP_COLOUR,
  parameter logic [2:0] DOWN_COLOUR = bar_graph_pkg::DOWN_COLOUR,
  parameter logic [2:0] BG_COLOUR   = bar_graph_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sample_valid,
  input  logic [7:0] sample_value,
  input  logic       redraw,
  output logic [9:0] x_coord,
  output logic [8:0] y_coord,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  import bar_graph_pkg::*;

  localparam int BW     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int CW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int STRIDE = BAR_W + BAR_GAP;

  state_e          state_q, state_d;
  logic [BW-1:0]   b_q, b_d;
  logic [8:0]      r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic            redraw_pend_q, redraw_pend_d;

  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [NUM_BARS*8-1:0] hist_flat;
  logic [7:0]            h_arr [NUM_BARS];
  logic [7:0]            h_cur, h_prv;
  logic [2:0]            bar_col;
  logic [8:0]            fill_top;

  // History is frozen for the whole frame and the pending sample is
  // committed in the DONE cycle, so a back-to-back frame sees it.
  bar_history_buffer #(
    .NUM_BARS (NUM_BARS),
    .GRAPH_H  (GRAPH_H)
  ) u_hist (
    .clk            (clk),
    .resetn         (resetn),
    .sample_valid_i (sample_valid),
    .sample_value_i (sample_value),
    .freeze_i       (state_q != ST_IDLE),
    .commit_i       (state_q == ST_DONE),
    .hist_o         (hist_flat)
  );

  for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_unpack
    assign h_arr[gi] = hist_flat[gi*8 +: 8];
  end

  // FSM next state and pixel counters (c inner, r middle, b outer).
  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    r_d           = r_q;
    c_d           = c_q;
    redraw_pend_d = redraw_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (redraw) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        b_d     = '0;
        r_d     = '0;
        c_d     = '0;
        state_d = ST_DRAW;
        if (redraw) redraw_pend_d = 1'b1;
      end
      ST_DRAW: begin
        if (redraw) redraw_pend_d = 1'b1;
        if (c_q == CW'(BAR_W - 1)) begin
          c_d = '0;
          if (r_q == 9'(GRAPH_H - 1)) begin
            r_d = '0;
            if (b_q == BW'(NUM_BARS - 1)) begin
              state_d = ST_DONE;
            end else begin
              b_d = b_q + 1'b1;
            end
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d       = (redraw_pend_q || redraw) ? ST_LOAD : ST_IDLE;
        redraw_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the next-cycle counters so that the
  // coordinates and plot appear together in the DRAW cycle they describe.
  always_comb begin
    h_cur    = h_arr[b_d];
    h_prv    = (b_d == '0) ? h_cur : h_arr[b_d - 1'b1];
    bar_col  = (h_cur >= h_prv) ? UP_COLOUR : DOWN_COLOUR;
    // Row index at which the filled part of the column starts.
    fill_top = 9'(GRAPH_H) - {1'b0, h_cur};
    plot_d   = (state_d == ST_DRAW);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    if (plot_d) begin
      x_d      = 10'(BASE_X) + 10'(b_d) * 10'(STRIDE) + 10'(c_d);
      y_d      = 9'(BASE_Y) + r_d;
      colour_d = (r_d >= fill_top) ? bar_col : BG_COLOUR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      b_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      redraw_pend_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      r_q           <= r_d;
      c_q           <= c_d;
      redraw_pend_q <= redraw_pend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign x_coord = x_q;
  assign y_coord = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bar_graph_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bar_graph_frame_scheduler
// Directed bench for the bar-graph frame scheduler. Bars are narrowed to 4
// pixels to keep frames short (8*200*4 = 6400 plot cycles); height, gap and
// origin are the defaults, so x = 40 + b*12 + c and y = 140 + r.
// -----------------------------------------------------------------------------
module tb_bar_graph_frame_scheduler;

  localparam int NB   = 8;
  localparam int BWD  = 4;
  localparam int GAP  = 8;
  localparam int GH   = 200;
  localparam int BX   = 40;
  localparam int BY   = 140;
  localparam int NPIX = NB * GH * BWD;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_value = 8'd0;
  logic       redraw = 1'b0;
  logic [9:0] x_coord;
  logic [8:0] y_coord;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Bench model of the bar heights currently stored.
  int mh [NB];

  // Results gathered by capture_frame.
  int         fr_plots, fr_bad, fr_done, fr_busy_low;
  int         fr_first_x, fr_first_y, fr_last_x, fr_last_y;
  int         fr_last_plot_cyc, fr_done_cyc, fr_replot_cyc;
  int         fr_col_cnt [NB];
  int         fr_bar3_min_y;
  logic [2:0] fr_bar3_col;
  string      fr_bad_msg;

  bar_graph_frame_scheduler #(
    .NUM_BARS (NB),
    .BAR_W    (BWD),
    .BAR_GAP  (GAP),
    .GRAPH_H  (GH),
    .BASE_X   (BX),
    .BASE_Y   (BY)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .sample_value (sample_value),
    .redraw       (redraw),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic model_push(input int v);
    for (int i = 0; i < NB - 1; i++) mh[i] = mh[i+1];
    mh[NB-1] = (v > GH) ? GH : v;
  endtask

  // Called at a negedge; the strobe is seen by the next posedge.
  task automatic push_sample(input int v);
    sample_valid = 1'b1;
    sample_value = 8'(v);
    @(negedge clk);
    sample_valid = 1'b0;
    model_push(v);
    $display("push sample %0d -> newest %0d", v, mh[NB-1]);
  endtask

  // Samples every cycle from the negedge after a redraw strobe was set,
  // compares each plotted pixel against the model, and optionally injects
  // samples or a redraw at given plot counts (-1 disables).
  task automatic capture_frame(input int n_frames, input int sv1_at, input int sv1_val,
                               input int sv2_at, input int sv2_val, input int rd_at);
    int p, q, b, r, c, ex, ey, h, ecol, post;
    bit inj1, inj2, injr;
    p = 0; post = -1; inj1 = 0; inj2 = 0; injr = 0;
    fr_bad = 0; fr_done = 0; fr_busy_low = 0; fr_bad_msg = "";
    fr_first_x = -1; fr_first_y = -1; fr_last_x = -1; fr_last_y = -1;
    fr_last_plot_cyc = -1; fr_done_cyc = -1; fr_replot_cyc = -1;
    fr_bar3_min_y = 9999; fr_bar3_col = 3'b000;
    for (int i = 0; i < NB; i++) fr_col_cnt[i] = 0;
    for (int cyc = 0; cyc < n_frames * (NPIX + 4) + 40; cyc++) begin
      @(negedge clk);
      redraw = 1'b0;
      sample_valid = 1'b0;
      if (fr_done < n_frames && !busy) fr_busy_low++;
      if (plot) begin
        q = p % NPIX;
        b = q / (GH * BWD);
        r = (q / BWD) % GH;
        c = q % BWD;
        ex = BX + b * (BWD + GAP) + c;
        ey = BY + r;
        h = mh[b];
        ecol = 2;
        if (b > 0) begin
          if (mh[b] < mh[b-1]) ecol = 4;
        end
        if (r < GH - h) ecol = 0;
        if (x_coord !== 10'(ex) || y_coord !== 9'(ey) || colour !== 3'(ecol)) begin
          if (fr_bad == 0)
            fr_bad_msg = $sformatf("pixel %0d got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                   p, x_coord, y_coord, colour, ex, ey, ecol);
          fr_bad++;
        end
        if (colour != 3'b000) fr_col_cnt[b]++;
        if (b == 3 && colour != 3'b000 && ey < fr_bar3_min_y) begin
          fr_bar3_min_y = ey;
          fr_bar3_col = colour;
        end
        if (p == 0) begin
          fr_first_x = x_coord;
          fr_first_y = y_coord;
        end
        fr_last_x = x_coord;
        fr_last_y = y_coord;
        if (fr_done == 0) fr_last_plot_cyc = cyc;
        if (fr_done > 0 && fr_replot_cyc < 0) fr_replot_cyc = cyc;
        p++;
      end
      if (done) begin
        fr_done++;
        if (fr_done == 1) fr_done_cyc = cyc;
        if (fr_done == n_frames) post = 3;
      end else if (post > 0) begin
        post--;
      end
      if (post == 0) break;
      if (!inj1 && sv1_at >= 0 && p == sv1_at) begin
        sample_valid = 1'b1; sample_value = 8'(sv1_val); inj1 = 1;
      end else if (!inj2 && sv2_at >= 0 && p == sv2_at) begin
        sample_valid = 1'b1; sample_value = 8'(sv2_val); inj2 = 1;
      end
      if (!injr && rd_at >= 0 && p == rd_at) begin
        redraw = 1'b1; injr = 1;
      end
    end
    fr_plots = p;
    $display("frame capture: %0d plots, %0d done pulses, %0d pixel differences", fr_plots, fr_done, fr_bad);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %0b expected 0", plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (x_coord !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x_coord); end
    checks++; if (y_coord !== 9'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y_coord); end
    checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d expected 0", colour); end
    resetn = 1'b1;
    for (int i = 0; i < NB; i++) mh[i] = 0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_empty_frame();
    int sum;
    redraw = 1'b1;
    capture_frame(1, -1, 0, -1, 0, -1);
    sum = 0;
    for (int i = 0; i < NB; i++) sum += fr_col_cnt[i];
    checks++; if (fr_plots !== NPIX) begin errors++; $display("FAIL empty_plots: got %0d expected %0d", fr_plots, NPIX); end
    checks++; if (fr_bad !== 0) begin errors++; $display("FAIL empty_pixels: %0d wrong, first %s", fr_bad, fr_bad_msg); end
    checks++; if (sum !== 0) begin errors++; $display("FAIL empty_coloured: got %0d coloured pixels expected 0", sum); end
    checks++; if (fr_first_x !== 40 || fr_first_y !== 140) begin errors++; $display("FAIL empty_first_pixel: got (%0d,%0d) expected (40,140)", fr_first_x, fr_first_y); end
    checks++; if (fr_last_x !== 127 || fr_last_y !== 339) begin errors++; $display("FAIL empty_last_pixel: got (%0d,%0d) expected (127,339)", fr_last_x, fr_last_y); end
    checks++; if (fr_done !== 1) begin errors++; $display("FAIL empty_done_count: got %0d expected 1", fr_done); end
    checks++; if (fr_done_cyc !== fr_last_plot_cyc + 1) begin errors++; $display("FAIL empty_done_timing: got cycle %0d expected %0d", fr_done_cyc, fr_last_plot_cyc + 1); end
    checks++; if (fr_busy_low !== 0) begin errors++; $display("FAIL empty_busy: low for %0d cycles expected 0", fr_busy_low); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_bars();
    push_sample(10); push_sample(20); push_sample(20); push_sample(5);
    push_sample(200); push_sample(255); push_sample(0);
    // Last sample together with redraw: the frame must already show it.
    sample_valid = 1'b1;
    sample_value = 8'd100;
    redraw = 1'b1;
    model_push(100);
    $display("push sample 100 with redraw");
    capture_frame(1, -1, 0, -1, 0, -1);
    checks++; if (fr_bad !== 0) begin errors++; $display("FAIL bars_pixels: %0d wrong, first %s", fr_bad, fr_bad_msg); end
    checks++; if (fr_col_cnt[5] !== GH * BWD) begin errors++; $display("FAIL bars_clamped_full: got %0d coloured expected %0d", fr_col_cnt[5], GH * BWD); end
    checks++; if (fr_col_cnt[3] !== 20) begin errors++; $display("FAIL bars_bar3_count: got %0d coloured expected 20", fr_col_cnt[3]); end
    checks++; if (fr_bar3_min_y !== 335) begin errors++; $display("FAIL bars_bar3_top: got y %0d expected 335", fr_bar3_min_y); end
    checks++; if (fr_bar3_col !== 3'b100) begin errors++; $display("FAIL bars_bar3_colour: got %0b expected 100", fr_bar3_col); end
    checks++; if (fr_col_cnt[6] !== 0) begin errors++; $display("FAIL bars_bar6_empty: got %0d coloured expected 0", fr_col_cnt[6]); end
    checks++; if (fr_col_cnt[7] !== 400) begin errors++; $display("FAIL bars_bar7_simul_push: got %0d coloured expected 400", fr_col_cnt[7]); end
    checks++; if (fr_done !== 1) begin errors++; $display("FAIL bars_done_count: got %0d expected 1", fr_done); end
  endtask

  task automatic test_pending();
    redraw = 1'b1;
    capture_frame(1, 1000, 50, 2000, 60, -1);
    checks++; if (fr_bad !== 0) begin errors++; $display("FAIL pending_frozen: %0d wrong, first %s", fr_bad, fr_bad_msg); end
    checks++; if (fr_plots !== NPIX) begin errors++; $display("FAIL pending_plots: got %0d expected %0d", fr_plots, NPIX); end
    checks++; if (fr_done !== 1) begin errors++; $display("FAIL pending_done_count: got %0d expected 1", fr_done); end
    // Only the later sample is committed at frame end.
    model_push(60);
  endtask

  task automatic test_back_to_back();
    redraw = 1'b1;
    capture_frame(2, -1, 0, -1, 0, 500);
    checks++; if (fr_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", fr_done); end
    checks++; if (fr_plots !== 2 * NPIX) begin errors++; $display("FAIL b2b_plots: got %0d expected %0d", fr_plots, 2 * NPIX); end
    checks++; if (fr_bad !== 0) begin errors++; $display("FAIL b2b_pixels_with_committed_sample: %0d wrong, first %s", fr_bad, fr_bad_msg); end
    checks++; if (fr_busy_low !== 0) begin errors++; $display("FAIL b2b_busy: low for %0d cycles expected 0", fr_busy_low); end
    checks++; if (fr_replot_cyc !== fr_done_cyc + 2) begin errors++; $display("FAIL b2b_reload_gap: got cycle %0d expected %0d", fr_replot_cyc, fr_done_cyc + 2); end
  endtask

  task automatic test_reset_abort();
    int p, extra_done, extra_busy;
    p = 0;
    redraw = 1'b1;
    for (int cyc = 0; cyc < NPIX + 10; cyc++) begin
      @(negedge clk);
      redraw = 1'b0;
      if (plot) p++;
      if (p == 3000) break;
    end
    checks++; if (p !== 3000) begin errors++; $display("FAIL abort_reach: got %0d plots expected 3000", p); end
    resetn = 1'b0;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_async: got plot=%0b busy=%0b expected 0 0", plot, busy); end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < NB; i++) mh[i] = 0;
    $display("reset pulsed at plot 3000");
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    checks++; if (extra_done !== 0 || extra_busy !== 0) begin errors++; $display("FAIL abort_quiet: got done=%0d busy=%0d expected 0 0", extra_done, extra_busy); end
    redraw = 1'b1;
    capture_frame(1, -1, 0, -1, 0, -1);
    checks++; if (fr_bad !== 0) begin errors++; $display("FAIL abort_history_cleared: %0d wrong, first %s", fr_bad, fr_bad_msg); end
    checks++; if (fr_plots !== NPIX || fr_done !== 1) begin errors++; $display("FAIL abort_recovery: got %0d plots %0d done expected %0d 1", fr_plots, fr_done, NPIX); end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_bars();
    test_pending();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
